// File: rtl/pong_pkg.sv
// Shared Pong constants and types: field geometry, paddle motion limits,
// the motion-state enum and the one-hot decision decoder.
package pong_pkg;

  localparam int FIELD_W  = 2560;
  localparam int FIELD_H  = 1920;
  localparam int PADDLE_H = 240;
  localparam int Y_MAX    = FIELD_H - PADDLE_H;
  localparam int Y_INIT   = 840;
  localparam int V_STEP   = 4;
  localparam int V_MAX    = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    FALL  = 2'd2,
    BRAKE = 2'd3
  } motion_state_e;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2
  } cmd_e;

  // Only a clean single-hot up or down moves the paddle; anything else holds.
  function automatic cmd_e decodeCmd(input logic up, input logic stay, input logic down);
    cmd_e cmd;
    case ({up, stay, down})
      3'b100:  cmd = CMD_UP;
      3'b001:  cmd = CMD_DOWN;
      default: cmd = CMD_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/paddle_motion_p1_if.sv
// Decision/position bundle between the player-1 controller side and the
// paddle motion stage.
interface paddle_motion_p1_if;

  logic        frame_tick;
  logic        up;
  logic        stay;
  logic        down;
  logic [12:0] p1_y;
  logic [7:0]  vel;
  logic        moving;
  logic        at_top;
  logic        at_bottom;
  logic        y_valid;

  modport master (
    output frame_tick, up, stay, down,
    input  p1_y, vel, moving, at_top, at_bottom, y_valid
  );

  modport slave (
    input  frame_tick, up, stay, down,
    output p1_y, vel, moving, at_top, at_bottom, y_valid
  );

endinterface

// File: rtl/paddle_step.sv
// Combinational paddle position step: signed add of the velocity in the
// travel direction, clamped to [0, Y_MAX]. Shared by both players.
module paddle_step #(
  parameter int Y_MAX = pong_pkg::Y_MAX
) (
  input  logic [12:0] y_i,
  input  logic [7:0]  vel_i,
  input  logic        dir_i,
  output logic [12:0] y_o,
  output logic        hit_o
);

  localparam logic signed [13:0] YMAX_S = 14'(Y_MAX);

  logic signed [13:0] sum;

  // 14-bit signed sum so an upward overshoot shows up as a negative value.
  always_comb begin
    if (dir_i) begin
      sum = $signed({1'b0, y_i}) + $signed({6'b0, vel_i});
    end else begin
      sum = $signed({1'b0, y_i}) - $signed({6'b0, vel_i});
    end
    y_o   = sum[12:0];
    hit_o = 1'b0;
    if (sum < 14'sd0) begin
      y_o   = '0;
      hit_o = 1'b1;
    end else if (sum > YMAX_S) begin
      y_o   = YMAX_S[12:0];
      hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/paddle_motion_p1.sv
// Player-1 paddle motion: integrates per-frame up/stay/down decisions into a
// velocity with acceleration and braking, then a clamped registered position.
module paddle_motion_p1 #(
  parameter int FIELD_H  = pong_pkg::FIELD_H,
  parameter int PADDLE_H = pong_pkg::PADDLE_H,
  parameter int Y_INIT   = pong_pkg::Y_INIT,
  parameter int V_STEP   = pong_pkg::V_STEP,
  parameter int V_MAX    = pong_pkg::V_MAX
) (
  input logic               clk,
  input logic               reset,
  paddle_motion_p1_if.slave bus
);

  import pong_pkg::*;

  localparam int Y_MAX = FIELD_H - PADDLE_H;

  motion_state_e state_q, state_d, stateVel;
  logic [12:0]   y_q, y_d, yStep;
  logic [7:0]    vel_q, vel_d, velNew, velAcc, velDown;
  logic [8:0]    velUp;
  logic          dir_q, dir_d, hit;
  logic          moving_q, moving_d, atTop_q, atTop_d, atBottom_q, atBottom_d;
  logic          yValid_q;
  cmd_e          cmd;

  assign cmd     = decodeCmd(bus.up, bus.stay, bus.down);
  assign velUp   = {1'b0, vel_q} + 9'(V_STEP);
  assign velAcc  = (velUp > 9'(V_MAX)) ? 8'(V_MAX) : velUp[7:0];
  assign velDown = (vel_q > 8'(V_STEP)) ? (vel_q - 8'(V_STEP)) : 8'd0;

  // State register: everything except y_valid only moves on a frame tick.
  always_ff @(posedge clk or posedge reset) begin : stateReg
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      y_q        <= 13'(Y_INIT);
      vel_q      <= '0;
      moving_q   <= 1'b0;
      atTop_q    <= 1'b0;
      atBottom_q <= 1'b0;
      yValid_q   <= 1'b0;
    end else begin
      yValid_q <= bus.frame_tick;
      if (bus.frame_tick) begin
        state_q    <= state_d;
        dir_q      <= dir_d;
        y_q        <= y_d;
        vel_q      <= vel_d;
        moving_q   <= moving_d;
        atTop_q    <= atTop_d;
        atBottom_q <= atBottom_d;
      end
    end
  end

  // Velocity and state before the bound clamp is applied.
  always_comb begin : nextState
    stateVel = state_q;
    velNew   = vel_q;
    dir_d    = dir_q;
    unique case (state_q)
      IDLE: begin
        velNew = '0;
        if (cmd == CMD_UP && y_q != 13'd0) begin
          stateVel = RISE;
          velNew   = 8'(V_STEP);
          dir_d    = 1'b0;
        end else if (cmd == CMD_DOWN && y_q != 13'(Y_MAX)) begin
          stateVel = FALL;
          velNew   = 8'(V_STEP);
          dir_d    = 1'b1;
        end
      end
      RISE, FALL: begin
        if ((state_q == RISE && cmd == CMD_UP) || (state_q == FALL && cmd == CMD_DOWN)) begin
          velNew = velAcc;
        end else begin
          stateVel = BRAKE;
          velNew   = velDown;
        end
      end
      BRAKE: begin
        if ((cmd == CMD_UP && !dir_q) || (cmd == CMD_DOWN && dir_q)) begin
          stateVel = dir_q ? FALL : RISE;
          velNew   = velAcc;
        end else begin
          velNew = velDown;
          if (velDown == 8'd0) begin
            stateVel = IDLE;
          end
        end
      end
    endcase
  end

  paddle_step #(
    .Y_MAX(Y_MAX)
  ) u_step (
    .y_i  (y_q),
    .vel_i(velNew),
    .dir_i(dir_d),
    .y_o  (yStep),
    .hit_o(hit)
  );

  // Hitting a bound kills the motion; flags follow the post-update position.
  always_comb begin : outputLogic
    state_d = stateVel;
    vel_d   = velNew;
    y_d     = yStep;
    if (hit) begin
      state_d = IDLE;
      vel_d   = '0;
    end
    moving_d   = (state_d != IDLE);
    atTop_d    = (y_d == 13'd0);
    atBottom_d = (y_d == 13'(Y_MAX));
  end

  assign bus.p1_y      = y_q;
  assign bus.vel       = vel_q;
  assign bus.moving    = moving_q;
  assign bus.at_top    = atTop_q;
  assign bus.at_bottom = atBottom_q;
  assign bus.y_valid   = yValid_q;

endmodule

// File: tb/tb_paddle_motion_p1.sv
// Bench for paddle_motion_p1: directed scenarios plus randomized command runs
// checked against a signed-heading behavioural model of the paddle.
module tb_paddle_motion_p1;

  localparam int YMAX = 1680;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  // Model: phase 0 = still, 1 = driving, 2 = coasting down; heading -1/+1.
  int mY, mSpeed, mHeading, mPhase;

  paddle_motion_p1_if bus();

  paddle_motion_p1 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic int decodeDir(input logic u, input logic s, input logic d);
    if (u && !s && !d) return -1;
    if (d && !u && !s) return 1;
    return 0;
  endfunction

  function automatic void modelReset();
    mY = 840; mSpeed = 0; mHeading = 1; mPhase = 0;
  endfunction

  function automatic void modelStep(input int c);
    int ny;
    case (mPhase)
      0: begin
        if (c == -1 && mY > 0) begin
          mPhase = 1; mHeading = -1; mSpeed = 4;
        end else if (c == 1 && mY < YMAX) begin
          mPhase = 1; mHeading = 1; mSpeed = 4;
        end else begin
          mSpeed = 0;
        end
      end
      1: begin
        if (c == mHeading) mSpeed = (mSpeed + 4 > 24) ? 24 : mSpeed + 4;
        else begin
          mPhase = 2;
          mSpeed = (mSpeed > 4) ? mSpeed - 4 : 0;
        end
      end
      default: begin
        if (c == mHeading) begin
          mPhase = 1;
          mSpeed = (mSpeed + 4 > 24) ? 24 : mSpeed + 4;
        end else begin
          mSpeed = (mSpeed > 4) ? mSpeed - 4 : 0;
          if (mSpeed == 0) mPhase = 0;
        end
      end
    endcase
    ny = mY + mHeading * mSpeed;
    if (ny < 0) begin
      ny = 0; mSpeed = 0; mPhase = 0;
    end else if (ny > YMAX) begin
      ny = YMAX; mSpeed = 0; mPhase = 0;
    end
    mY = ny;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.up = 1'b0; bus.stay = 1'b0; bus.down = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  // One frame tick; returns at the following falling edge with outputs updated.
  task automatic applyStimulus(input logic u, input logic s, input logic d);
    @(negedge clk);
    bus.frame_tick = 1'b1; bus.up = u; bus.stay = s; bus.down = d;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic sawValid;
    applyReset();
    sawValid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.y_valid) sawValid = 1'b1;
    end
    total++;
    if (bus.p1_y !== 13'd840 || bus.vel !== 8'd0 || bus.moving !== 1'b0 ||
        bus.at_top !== 1'b0 || bus.at_bottom !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: y=%0d vel=%0d mov=%b top=%b bot=%b, want y=840 vel=0 flags 0",
               bus.p1_y, bus.vel, bus.moving, bus.at_top, bus.at_bottom);
    end
    total++;
    if (sawValid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_no_valid: y_valid seen=%b, want 0", sawValid);
    end
  endtask

  task automatic test_accel();
    int ev[3] = '{4, 8, 12};
    int ey[3] = '{836, 828, 816};
    applyReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      total++;
      if (bus.vel !== 8'(ev[i]) || bus.p1_y !== 13'(ey[i]) || bus.y_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL accel_%0d: vel=%0d y=%0d valid=%b, want vel=%0d y=%0d valid=1",
                 i, bus.vel, bus.p1_y, bus.y_valid, ev[i], ey[i]);
      end
      @(negedge clk);
      total++;
      if (bus.y_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL valid_pulse_%0d: y_valid=%b, want 0", i, bus.y_valid);
      end
    end
  endtask

  task automatic test_saturate();
    applyReset();
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 6) begin
        total++;
        if (bus.vel !== 8'd24) begin
          bad++;
          $display("[TB] FAIL saturate_t6: vel=%0d, want 24", bus.vel);
        end
      end
    end
    total++;
    if (bus.vel !== 8'd24 || bus.p1_y !== 13'd732) begin
      bad++;
      $display("[TB] FAIL saturate_t7: vel=%0d y=%0d, want vel=24 y=732", bus.vel, bus.p1_y);
    end
  endtask

  task automatic test_brake();
    int ev[3] = '{8, 4, 0};
    int ey[3] = '{808, 804, 804};
    logic em[3] = '{1'b1, 1'b1, 1'b0};
    applyReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      total++;
      if (bus.vel !== 8'(ev[i]) || bus.p1_y !== 13'(ey[i]) || bus.moving !== em[i]) begin
        bad++;
        $display("[TB] FAIL brake_%0d: vel=%0d y=%0d mov=%b, want vel=%0d y=%0d mov=%b",
                 i, bus.vel, bus.p1_y, bus.moving, ev[i], ey[i], em[i]);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.vel !== 8'd4 || bus.p1_y !== 13'd808 || bus.moving !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reverse_start: vel=%0d y=%0d mov=%b, want vel=4 y=808 mov=1",
               bus.vel, bus.p1_y, bus.moving);
    end
  endtask

  task automatic test_bound(input logic goDown);
    int n;
    int want;
    want = goDown ? YMAX : 0;
    applyReset();
    n = 0;
    while ((goDown ? !bus.at_bottom : !bus.at_top) && n < 200) begin
      applyStimulus(!goDown, 1'b0, goDown);
      modelStep(goDown ? 1 : -1);
      n++;
      total++;
      if (bus.p1_y !== 13'(mY) || bus.vel !== 8'(mSpeed)) begin
        bad++;
        $display("[TB] FAIL bound_run_%0d: y=%0d vel=%0d, want y=%0d vel=%0d",
                 n, bus.p1_y, bus.vel, mY, mSpeed);
      end
    end
    total++;
    if (bus.p1_y !== 13'(want) || bus.vel !== 8'd0 || bus.moving !== 1'b0 ||
        bus.at_top !== !goDown || bus.at_bottom !== goDown) begin
      bad++;
      $display("[TB] FAIL bound_land: y=%0d vel=%0d mov=%b top=%b bot=%b ticks=%0d, want y=%0d vel=0 mov=0",
               bus.p1_y, bus.vel, bus.moving, bus.at_top, bus.at_bottom, n, want);
    end
    repeat (3) begin
      applyStimulus(!goDown, 1'b0, goDown);
      total++;
      if (bus.p1_y !== 13'(want) || bus.moving !== 1'b0 || bus.vel !== 8'd0) begin
        bad++;
        $display("[TB] FAIL bound_hold: y=%0d mov=%b vel=%0d, want y=%0d mov=0 vel=0",
                 bus.p1_y, bus.moving, bus.vel, want);
      end
    end
  endtask

  task automatic test_both_high();
    applyReset();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    total++;
    if (bus.vel !== 8'd4 || bus.p1_y !== 13'd824 || bus.moving !== 1'b1) begin
      bad++;
      $display("[TB] FAIL both_high: vel=%0d y=%0d mov=%b, want vel=4 y=824 mov=1",
               bus.vel, bus.p1_y, bus.moving);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    total++;
    if (bus.vel !== 8'd0 || bus.p1_y !== 13'd824 || bus.moving !== 1'b0) begin
      bad++;
      $display("[TB] FAIL multi_hot_stop: vel=%0d y=%0d mov=%b, want vel=0 y=824 mov=0",
               bus.vel, bus.p1_y, bus.moving);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.vel !== 8'd16 || bus.p1_y !== 13'd880) begin
      bad++;
      $display("[TB] FAIL pre_reset: vel=%0d y=%0d, want vel=16 y=880", bus.vel, bus.p1_y);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.p1_y !== 13'd840 || bus.vel !== 8'd0 || bus.moving !== 1'b0 ||
        bus.at_top !== 1'b0 || bus.at_bottom !== 1'b0 || bus.y_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: y=%0d vel=%0d mov=%b top=%b bot=%b valid=%b, want 840/0/0/0/0/0",
               bus.p1_y, bus.vel, bus.moving, bus.at_top, bus.at_bottom, bus.y_valid);
    end
    @(negedge clk);
    bus.frame_tick = 1'b1; bus.down = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.frame_tick = 1'b0;
    @(negedge clk);
    modelReset();
    total++;
    if (bus.p1_y !== 13'd840 || bus.vel !== 8'd0 || bus.y_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tick_at_release: y=%0d vel=%0d valid=%b, want y=840 vel=0 valid=0",
               bus.p1_y, bus.vel, bus.y_valid);
    end
  endtask

  task automatic test_hold_inputs();
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      bus.up = 1'($urandom); bus.stay = 1'($urandom); bus.down = 1'($urandom);
      total++;
      if (bus.p1_y !== 13'd836 || bus.vel !== 8'd4 || bus.y_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_no_tick: y=%0d vel=%0d valid=%b, want y=836 vel=4 valid=0",
                 bus.p1_y, bus.vel, bus.y_valid);
      end
    end
  endtask

  task automatic test_random();
    logic       expValid, tickNow, pu, ps, pd;
    logic [25:0] got, want;
    int         holdLeft;
    applyReset();
    expValid = 1'b0;
    holdLeft = 0;
    pu = 1'b0; ps = 1'b1; pd = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      got  = {bus.p1_y, bus.vel, bus.moving, bus.at_top, bus.at_bottom, bus.y_valid};
      want = {13'(mY), 8'(mSpeed), (mPhase != 0), (mY == 0), (mY == YMAX), expValid};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL random_%0d: y=%0d vel=%0d mov=%b top=%b bot=%b valid=%b, want y=%0d vel=%0d mov=%b top=%b bot=%b valid=%b",
                 i, got[25:13], got[12:5], got[4], got[3], got[2], got[1],
                 want[25:13], want[12:5], want[4], want[3], want[2], want[1]);
      end
      if (holdLeft == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: begin pu = 1'b1; ps = 1'b0; pd = 1'b0; end
          4, 5, 6, 7: begin pu = 1'b0; ps = 1'b0; pd = 1'b1; end
          8:          begin pu = 1'b0; ps = 1'b1; pd = 1'b0; end
          default:    begin pu = 1'($urandom); ps = 1'($urandom); pd = 1'($urandom); end
        endcase
        holdLeft = $urandom_range(1, 40);
      end
      tickNow = ($urandom_range(0, 3) != 0);
      bus.frame_tick = tickNow;
      if (tickNow) begin
        holdLeft--;
        bus.up = pu; bus.stay = ps; bus.down = pd;
        modelStep(decodeDir(pu, ps, pd));
      end else begin
        bus.up = 1'($urandom); bus.stay = 1'($urandom); bus.down = 1'($urandom);
      end
      expValid = tickNow;
    end
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.up = 1'b0; bus.stay = 1'b0; bus.down = 1'b0;
    modelReset();
    test_reset();
    test_accel();
    test_saturate();
    test_brake();
    test_bound(1'b1);
    test_bound(1'b0);
    test_both_high();
    test_reset_mid();
    test_hold_inputs();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
